// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: assembles header + row words from a valid/ready
// word stream into one column frame. It then presents the frame on FrameData
// and ColAddr, and fires a single one-hot FrameStrobe pulse. One idle cycle
// on each side of the pulse gives setup and hold for the tile frame latches.

// One tile-row slot of the frame buffer. It clears on a new good header and
// loads when the row pointer selects it.
module frame_row_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wrEn,
    input  logic [W-1:0] wrData,
    output logic [W-1:0] rowData
);

    // Row storage: a clear takes priority over a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rowData <= '0;
        else if (clr)  rowData <= '0;
        else if (wrEn) rowData <= wrData;
    end

endmodule

module frame_config_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumberOfRows    = 16,
    parameter int NumberOfCols    = 16
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [31:0]                             s_data,
    input  logic                                    s_valid,
    output logic                                    s_ready,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic [7:0]                              ColAddr,
    output logic                                    busy,
    output logic                                    error,
    output logic [15:0]                             frame_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    state_t state, nextState;

    logic [7:0] frameIdx;   // strobe bit to fire for the frame being built
    logic [7:0] rowCount;   // N from the header (also the drain length)
    logic [7:0] rowPtr;     // next row slot / words consumed so far

    // Header field decode. It is only meaningful when a word is offered in IDLE.
    logic [7:0] hdrMagic, hdrCol, hdrFrame, hdrRows;
    logic       magicOk, colOk, frameOk, rowsOk, goodHdr;
    logic       xfer, lastWord;

    assign hdrMagic = s_data[31:24];
    assign hdrCol   = s_data[23:16];
    assign hdrFrame = s_data[15:8];
    assign hdrRows  = s_data[7:0];

    assign magicOk  = (hdrMagic == 8'hFA);
    assign colOk    = ({1'b0, hdrCol}   < 9'(NumberOfCols));
    assign frameOk  = ({1'b0, hdrFrame} < 9'(MaxFramesPerCol));
    assign rowsOk   = (hdrRows != 8'd0) && ({1'b0, hdrRows} <= 9'(NumberOfRows));
    assign goodHdr  = magicOk && colOk && frameOk && rowsOk;

    assign xfer     = s_valid && s_ready;
    assign lastWord = (8'(rowPtr + 8'd1) == rowCount);

    // Control strobes decoded from the current state and this cycle's transfer.
    logic                       hdrAccept, hdrReject, drainStart, rowWrite, ptrStep, frameDone;
    logic [MaxFramesPerCol-1:0] strobeNext;

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state logic. SETUP/STROBE/HOLD are fixed single-cycle phases.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (goodHdr)                           nextState = LOAD;
                    else if (magicOk && hdrRows != 8'd0)   nextState = DRAIN;
                end
            end
            LOAD:    if (xfer && lastWord) nextState = SETUP;
            DRAIN:   if (xfer && lastWord) nextState = IDLE;
            SETUP:   nextState = STROBE;
            STROBE:  nextState = HOLD;
            HOLD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output/control decode. The strobe is staged from nextState so the
    // registered pulse lines up exactly with the STROBE state.
    always_comb begin
        hdrAccept  = (state == IDLE) && xfer && goodHdr;
        hdrReject  = (state == IDLE) && xfer && !goodHdr;
        drainStart = hdrReject && magicOk && (hdrRows != 8'd0);
        rowWrite   = (state == LOAD) && xfer;
        ptrStep    = xfer && ((state == LOAD) || (state == DRAIN));
        frameDone  = (state == HOLD);
        strobeNext = '0;
        for (int i = 0; i < MaxFramesPerCol; i++)
            strobeNext[i] = (nextState == STROBE) && (frameIdx == 8'(i));
    end

    // Frame context: target strobe, row count and row pointer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frameIdx <= '0;
            rowCount <= '0;
            rowPtr   <= '0;
        end else if (hdrAccept) begin
            frameIdx <= hdrFrame;
            rowCount <= hdrRows;
            rowPtr   <= '0;
        end else if (drainStart) begin
            rowCount <= hdrRows;
            rowPtr   <= '0;
        end else if (ptrStep) begin
            rowPtr   <= 8'(rowPtr + 8'd1);
        end
    end

    // Column address is latched only by a good header, so drained frames leave it alone.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          ColAddr <= '0;
        else if (hdrAccept) ColAddr <= hdrCol;
    end

    // Registered one-hot strobe. Reset kills a pulse in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) FrameStrobe <= '0;
        else       FrameStrobe <= strobeNext;
    end

    // Sticky protocol error and the completed-frame counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            error       <= 1'b0;
            frame_count <= '0;
        end else begin
            if (hdrReject) error <= 1'b1;
            if (frameDone) frame_count <= 16'(frame_count + 16'd1);
        end
    end

    // Handshake and busy are registered from the state being entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s_ready <= 1'b1;
            busy    <= 1'b0;
        end else begin
            s_ready <= (nextState == IDLE) || (nextState == LOAD) || (nextState == DRAIN);
            busy    <= (nextState != IDLE);
        end
    end

    // Frame buffer: one slot per tile row.
    for (genvar r = 0; r < NumberOfRows; r++) begin : gRow
        frame_row_slot #(.W(FrameBitsPerRow)) uSlot (
            .clk     (CLK),
            .rst     (RESET),
            .clr     (hdrAccept),
            .wrEn    (rowWrite && (rowPtr == 8'(r))),
            .wrData  (s_data[FrameBitsPerRow-1:0]),
            .rowData (FrameData[r*FrameBitsPerRow +: FrameBitsPerRow])
        );
    end

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Directed bench for frame_config_sequencer: single frame timing, back-to-back
// full frames, drain of a bad header, bad magic, stalled loads and reset
// during the strobe.
module tb_frame_config_sequencer;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_ready;
    logic [511:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic [7:0]   ColAddr;
    logic         busy;
    logic         error;
    logic [15:0]  frame_count;

    int nVec = 0;
    int nMis = 0;

    typedef struct packed {
        logic [19:0]  stb;
        logic [7:0]   col;
        logic [511:0] data;
    } strobeEvt_t;

    strobeEvt_t evtQ[$];
    logic [19:0] prevStrobe = '0;
    int          backToBack = 0;
    int          notOneHot  = 0;

    frame_config_sequencer #(
        .FrameBitsPerRow(32), .MaxFramesPerCol(20), .NumberOfRows(16), .NumberOfCols(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .ColAddr(ColAddr),
        .busy(busy), .error(error), .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;

    // Record every strobe and flag pulses that are too long or not one-hot.
    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            evtQ.push_back('{stb: FrameStrobe, col: ColAddr, data: FrameData});
            if ($countones(FrameStrobe) != 1) notOneHot++;
            if (prevStrobe != '0) backToBack++;
        end
        prevStrobe = FrameStrobe;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rowOf(input logic [511:0] d, input int r);
        return d[32*r +: 32];
    endfunction

    task automatic waitNeg(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Offer one word from a negedge. Returns at the negedge after it transfers,
    // with the number of cycles the word waited for s_ready.
    task automatic sendWord(input logic [31:0] w, output int stalls);
        stalls  = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && stalls < 50) begin
            @(negedge CLK);
            stalls++;
        end
        chk("ready_wait", {63'd0, s_ready}, 64'd1);
        @(negedge CLK);
        s_valid = 1'b0;
        s_data  = 32'hDEAD_BEEF;
    endtask

    task automatic pulseReset();
        RESET = 1'b1;
        waitNeg(2);
        RESET = 1'b0;
        waitNeg(1);
    endtask

    initial begin
        int st, stSum, base, gap;
        RESET   = 1'b1;
        s_valid = 1'b0;
        s_data  = 32'h0;
        waitNeg(2);
        chk("rst_ready", {63'd0, s_ready}, 64'd1);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_strobe", {44'd0, FrameStrobe}, 64'd0);
        chk("rst_data_zero", {63'd0, FrameData == '0}, 64'd1);
        chk("rst_count", {48'd0, frame_count}, 64'd0);
        RESET = 1'b0;
        waitNeg(1);

        // ---- single good frame: col 3, frame 5, N=2
        sendWord(32'hFA03_0502, st);
        chk("t1_busy_load", {63'd0, busy}, 64'd1);
        sendWord(32'h1111_1111, st);
        sendWord(32'h2222_2222, st);
        chk("t1_setup_strobe", {44'd0, FrameStrobe}, 64'd0);
        chk("t1_setup_ready", {63'd0, s_ready}, 64'd0);
        chk("t1_row1", {32'd0, rowOf(FrameData, 1)}, 64'h2222_2222);
        waitNeg(1);
        chk("t1_strobe", {44'd0, FrameStrobe}, 64'h00020);
        chk("t1_col", {56'd0, ColAddr}, 64'd3);
        chk("t1_row0", {32'd0, rowOf(FrameData, 0)}, 64'h1111_1111);
        chk("t1_row2", {32'd0, rowOf(FrameData, 2)}, 64'd0);
        chk("t1_row15", {32'd0, rowOf(FrameData, 15)}, 64'd0);
        waitNeg(1);
        chk("t1_hold_strobe", {44'd0, FrameStrobe}, 64'd0);
        chk("t1_hold_ready", {63'd0, s_ready}, 64'd0);
        chk("t1_hold_count", {48'd0, frame_count}, 64'd0);
        waitNeg(1);
        chk("t1_ready_back", {63'd0, s_ready}, 64'd1);
        chk("t1_count", {48'd0, frame_count}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd0);
        chk("t1_error", {63'd0, error}, 64'd0);

        // ---- back-to-back N=16 frames with valid held high
        pulseReset();
        base = evtQ.size();
        stSum = 0;
        sendWord(32'hFA01_0010, st);
        chk("t2_hdrA_stall", 64'(st), 64'd0);
        for (int r = 0; r < 16; r++) begin
            sendWord(32'hA000_0000 + 32'(r), st);
            stSum += st;
        end
        sendWord(32'hFA02_1310, st);
        chk("t2_hdrB_stall", 64'(st), 64'd3);
        for (int r = 0; r < 16; r++) begin
            sendWord(32'hB000_0000 + 32'(r), st);
            stSum += st;
        end
        chk("t2_data_stalls", 64'(stSum), 64'd0);
        waitNeg(3);
        chk("t2_count", {48'd0, frame_count}, 64'd2);
        chk("t2_ready", {63'd0, s_ready}, 64'd1);
        chk("t2_nevents", 64'(evtQ.size() - base), 64'd2);
        if (evtQ.size() - base == 2) begin
            chk("t2_A_stb", {44'd0, evtQ[base].stb}, 64'h00001);
            chk("t2_A_col", {56'd0, evtQ[base].col}, 64'd1);
            chk("t2_A_row0", {32'd0, rowOf(evtQ[base].data, 0)}, 64'hA000_0000);
            chk("t2_A_row7", {32'd0, rowOf(evtQ[base].data, 7)}, 64'hA000_0007);
            chk("t2_A_row15", {32'd0, rowOf(evtQ[base].data, 15)}, 64'hA000_000F);
            chk("t2_B_stb", {44'd0, evtQ[base+1].stb}, 64'h80000);
            chk("t2_B_col", {56'd0, evtQ[base+1].col}, 64'd2);
            chk("t2_B_row0", {32'd0, rowOf(evtQ[base+1].data, 0)}, 64'hB000_0000);
            chk("t2_B_row15", {32'd0, rowOf(evtQ[base+1].data, 15)}, 64'hB000_000F);
        end

        // ---- frame index 20: error, drain 3 words, nothing strobed
        base = evtQ.size();
        stSum = 0;
        sendWord(32'hFA00_1403, st);
        stSum += st;
        chk("t4_error", {63'd0, error}, 64'd1);
        chk("t4_busy_drain", {63'd0, busy}, 64'd1);
        sendWord(32'h1234_5678, st);
        stSum += st;
        sendWord(32'h8765_4321, st);
        stSum += st;
        sendWord(32'hFA01_0001, st);
        stSum += st;
        chk("t4_drain_stalls", 64'(stSum), 64'd0);
        chk("t4_busy_after", {63'd0, busy}, 64'd0);
        waitNeg(4);
        chk("t4_nevents", 64'(evtQ.size() - base), 64'd0);
        chk("t4_row0_kept", {32'd0, rowOf(FrameData, 0)}, 64'hB000_0000);
        chk("t4_row15_kept", {32'd0, rowOf(FrameData, 15)}, 64'hB000_000F);
        chk("t4_col_kept", {56'd0, ColAddr}, 64'd2);
        chk("t4_count", {48'd0, frame_count}, 64'd2);

        // ---- bad magic, then a good frame: col 5, frame 1, N=1
        sendWord(32'hAB00_0001, st);
        chk("t3_error", {63'd0, error}, 64'd1);
        chk("t3_busy", {63'd0, busy}, 64'd0);
        sendWord(32'hFA05_0101, st);
        sendWord(32'h3C3C_3C3C, st);
        waitNeg(1);
        chk("t3_strobe", {44'd0, FrameStrobe}, 64'h00002);
        chk("t3_col", {56'd0, ColAddr}, 64'd5);
        chk("t3_row0", {32'd0, rowOf(FrameData, 0)}, 64'h3C3C_3C3C);
        chk("t3_row1_clr", {32'd0, rowOf(FrameData, 1)}, 64'd0);
        chk("t3_row15_clr", {32'd0, rowOf(FrameData, 15)}, 64'd0);
        waitNeg(2);
        chk("t3_count", {48'd0, frame_count}, 64'd3);

        // ---- valid gaps during LOAD: col 15, frame 10, N=4
        base = evtQ.size();
        sendWord(32'hFA0F_0A04, st);
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(0, 3));
            waitNeg(gap);
            chk("t5_no_early_strobe", 64'(evtQ.size() - base), 64'd0);
            sendWord(32'hC000_0000 + 32'(i), st);
        end
        waitNeg(1);
        chk("t5_strobe", {44'd0, FrameStrobe}, 64'h00400);
        chk("t5_col", {56'd0, ColAddr}, 64'd15);
        chk("t5_row0", {32'd0, rowOf(FrameData, 0)}, 64'hC000_0000);
        chk("t5_row3", {32'd0, rowOf(FrameData, 3)}, 64'hC000_0003);
        chk("t5_row4", {32'd0, rowOf(FrameData, 4)}, 64'd0);
        waitNeg(2);
        chk("t5_count", {48'd0, frame_count}, 64'd4);

        // ---- reset in the STROBE cycle
        sendWord(32'hFA07_0303, st);
        sendWord(32'h0000_0001, st);
        sendWord(32'h0000_0002, st);
        sendWord(32'h0000_0003, st);
        waitNeg(1);
        chk("t6_strobe_pre", {44'd0, FrameStrobe}, 64'h00008);
        #1 RESET = 1'b1;
        #1;
        chk("t6_rst_strobe", {44'd0, FrameStrobe}, 64'd0);
        chk("t6_rst_data_zero", {63'd0, FrameData == '0}, 64'd1);
        chk("t6_rst_col", {56'd0, ColAddr}, 64'd0);
        chk("t6_rst_ready", {63'd0, s_ready}, 64'd1);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_error", {63'd0, error}, 64'd0);
        chk("t6_rst_count", {48'd0, frame_count}, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
        waitNeg(1);
        sendWord(32'hFA02_0001, st);
        sendWord(32'h5A5A_5A5A, st);
        waitNeg(1);
        chk("t6_strobe", {44'd0, FrameStrobe}, 64'h00001);
        chk("t6_col", {56'd0, ColAddr}, 64'd2);
        chk("t6_row0", {32'd0, rowOf(FrameData, 0)}, 64'h5A5A_5A5A);
        waitNeg(2);
        chk("t6_count", {48'd0, frame_count}, 64'd1);
        chk("t6_error", {63'd0, error}, 64'd0);

        chk("strobe_back_to_back", 64'(backToBack), 64'd0);
        chk("strobe_one_hot", 64'(notOneHot), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
